// File: rtl/ycc422_to_rgb444.sv
// ---------------------------------------------------------------------------
// ycc422_to_rgb444
//
// Converts a YCbCr 4:2:2 pixel stream (one Y plus one chroma byte per clock)
// into 8-bit RGB 4:4:4 using BT.601 studio-range coefficients. Four register
// stages (input capture, offset removal, products, sum/limit), so RGB, syncs
// and DE all emerge exactly 4 clocks after they enter. No stalls.
//
// Build option:
//   OUT_CLAMP_EN  defined   -> each component saturates to 0..255
//                 undefined -> each component is bits [7:0] of the shifted
//                              sum (wraps). Latency is identical.
//
// Ports:
//   clk            pixel clock, rising edge
//   rst            synchronous active-high reset
//   hdmi_d[15:0]   Y + chroma byte (placement selected by Y_IN_HIGH)
//   hdmi_de        active video
//   hdmi_hsync     horizontal sync (polarity passed through)
//   hdmi_vsync     vertical sync (polarity passed through)
//   r_out/g_out/b_out  RGB pixel, forced to 0 while de_out is low
//   hsync_out/vsync_out/de_out  syncs and DE aligned with RGB
// ---------------------------------------------------------------------------
module ycc422_to_rgb444 #(
  parameter int Y_IN_HIGH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] hdmi_d,
  input  logic        hdmi_de,
  input  logic        hdmi_hsync,
  input  logic        hdmi_vsync,
  output logic [7:0]  r_out,
  output logic [7:0]  g_out,
  output logic [7:0]  b_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        de_out
);

  logic [7:0] y_in, c_in;
  assign y_in = (Y_IN_HIGH != 0) ? hdmi_d[15:8] : hdmi_d[7:0];
  assign c_in = (Y_IN_HIGH != 0) ? hdmi_d[7:0]  : hdmi_d[15:8];

  // Chroma phase of the pixel currently on the input: 0 = Cb, 1 = Cr.
  logic phase_q;
  always_ff @(posedge clk) begin
    if (rst || !hdmi_de) phase_q <= 1'b0;
    else                 phase_q <= ~phase_q;
  end

  // ---------------- S1: input capture ----------------
  logic [7:0] y1_q, c1_q;
  logic       de1_q, hs1_q, vs1_q, ph1_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      y1_q <= '0; c1_q <= '0; de1_q <= 1'b0;
      hs1_q <= 1'b0; vs1_q <= 1'b0; ph1_q <= 1'b0;
    end else begin
      y1_q  <= y_in;    c1_q  <= c_in;    de1_q <= hdmi_de;
      hs1_q <= hdmi_hsync; vs1_q <= hdmi_vsync; ph1_q <= phase_q;
    end
  end

  // ---------------- S2: chroma pairing and offsets ----------------
  // A phase-0 pixel in S1 borrows Cr from the pixel now on the input, which
  // is its phase-1 partner when DE is still high; otherwise the line ended
  // on an odd pixel and a neutral Cr is used. A phase-1 pixel reuses the Cb
  // held from its phase-0 partner.
  logic [7:0]        cb_hold_q;
  logic [7:0]        cb_sel_d, cr_sel_d;
  logic signed [9:0] ys2_d, cb2_d, cr2_d;
  logic signed [9:0] ys2_q, cb2_q, cr2_q;
  logic              de2_q, hs2_q, vs2_q;

  always_comb begin
    cb_sel_d = c1_q;
    cr_sel_d = 8'd128;
    if (!ph1_q) begin
      cb_sel_d = c1_q;
      cr_sel_d = hdmi_de ? c_in : 8'd128;
    end else begin
      cb_sel_d = cb_hold_q;
      cr_sel_d = c1_q;
    end
    ys2_d = $signed({2'b00, y1_q})     - 10'sd16;
    cb2_d = $signed({2'b00, cb_sel_d}) - 10'sd128;
    cr2_d = $signed({2'b00, cr_sel_d}) - 10'sd128;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cb_hold_q <= '0;
      ys2_q <= '0; cb2_q <= '0; cr2_q <= '0;
      de2_q <= 1'b0; hs2_q <= 1'b0; vs2_q <= 1'b0;
    end else begin
      if (de1_q && !ph1_q) cb_hold_q <= c1_q;
      ys2_q <= ys2_d; cb2_q <= cb2_d; cr2_q <= cr2_d;
      de2_q <= de1_q; hs2_q <= hs1_q; vs2_q <= vs1_q;
    end
  end

  // ---------------- S3: coefficient products ----------------
  logic signed [19:0] ys_x, cb_x, cr_x;
  assign ys_x = $signed({{10{ys2_q[9]}}, ys2_q});
  assign cb_x = $signed({{10{cb2_q[9]}}, cb2_q});
  assign cr_x = $signed({{10{cr2_q[9]}}, cr2_q});

  logic signed [19:0] py_q, prcr_q, pgcb_q, pgcr_q, pbcb_q;
  logic               de3_q, hs3_q, vs3_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      py_q <= '0; prcr_q <= '0; pgcb_q <= '0; pgcr_q <= '0; pbcb_q <= '0;
      de3_q <= 1'b0; hs3_q <= 1'b0; vs3_q <= 1'b0;
    end else begin
      py_q   <= ys_x * 20'sd298;
      prcr_q <= cr_x * 20'sd409;
      pgcb_q <= cb_x * 20'sd100;
      pgcr_q <= cr_x * 20'sd208;
      pbcb_q <= cb_x * 20'sd516;
      de3_q <= de2_q; hs3_q <= hs2_q; vs3_q <= vs2_q;
    end
  end

  // ---------------- S4: sum, round, shift, limit ----------------
  function automatic logic [7:0] limit(input logic signed [19:0] sum);
    logic signed [19:0] sh;
    sh = sum >>> 8;
`ifdef OUT_CLAMP_EN
    if (sh < 0)             limit = 8'd0;
    else if (sh > 20'sd255) limit = 8'd255;
    else                    limit = sh[7:0];
`else
    limit = sh[7:0];
`endif
  endfunction

  logic signed [19:0] sr_d, sg_d, sb_d;
  always_comb begin
    sr_d = py_q + prcr_q + 20'sd128;
    sg_d = py_q - pgcb_q - pgcr_q + 20'sd128;
    sb_d = py_q + pbcb_q + 20'sd128;
  end

  logic [7:0] r_q, g_q, b_q;
  logic       de4_q, hs4_q, vs4_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0; g_q <= '0; b_q <= '0;
      de4_q <= 1'b0; hs4_q <= 1'b0; vs4_q <= 1'b0;
    end else begin
      r_q <= de3_q ? limit(sr_d) : 8'd0;
      g_q <= de3_q ? limit(sg_d) : 8'd0;
      b_q <= de3_q ? limit(sb_d) : 8'd0;
      de4_q <= de3_q; hs4_q <= hs3_q; vs4_q <= vs3_q;
    end
  end

  assign r_out     = r_q;
  assign g_out     = g_q;
  assign b_out     = b_q;
  assign de_out    = de4_q;
  assign hsync_out = hs4_q;
  assign vsync_out = vs4_q;

endmodule

// File: tb/tb_ycc422_to_rgb444.sv
// ---------------------------------------------------------------------------
// Testbench for ycc422_to_rgb444. Directed pixel pairs with hand-computed
// RGB results are queued as they are driven; a monitor pops and compares on
// every DE-high output and checks syncs/DE against a 4-clock delayed copy of
// the inputs on every cycle.
// ---------------------------------------------------------------------------
module tb_ycc422_to_rgb444;

  localparam int Y_IN_HIGH = 1;

`ifdef OUT_CLAMP_EN
  localparam logic [7:0] B_RED = 8'd0;
  localparam logic [7:0] R_OV  = 8'd255;
  localparam logic [7:0] B_OV  = 8'd255;
  localparam logic [7:0] B_MIX = 8'd0;
  localparam logic [7:0] B_ODD = 8'd255;
`else
  localparam logic [7:0] B_RED = 8'd255;
  localparam logic [7:0] R_OV  = 8'd225;
  localparam logic [7:0] B_OV  = 8'd22;
  localparam logic [7:0] B_MIX = 8'd251;
  localparam logic [7:0] B_ODD = 8'd144;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] hdmi_d;
  logic        hdmi_de, hdmi_hsync, hdmi_vsync;
  logic [7:0]  r_out, g_out, b_out;
  logic        hsync_out, vsync_out, de_out;

  always #5 clk = ~clk;

  ycc422_to_rgb444 #(.Y_IN_HIGH(Y_IN_HIGH)) dut (
    .clk(clk), .rst(rst), .hdmi_d(hdmi_d), .hdmi_de(hdmi_de),
    .hdmi_hsync(hdmi_hsync), .hdmi_vsync(hdmi_vsync),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out)
  );

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  rgb_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Expected {de,hsync,vsync}: inputs delayed by 4 clocks, cleared by reset.
  logic [2:0] dly [4];
  always @(posedge clk) begin
    if (rst) begin
      dly <= '{default: 3'b000};
    end else begin
      dly[0] <= {hdmi_de, hdmi_hsync, hdmi_vsync};
      dly[1] <= dly[0];
      dly[2] <= dly[1];
      dly[3] <= dly[2];
    end
  end

  // Monitor
  always @(negedge clk) begin
    rgb_t e;
    vectors++;
    if ({de_out, hsync_out, vsync_out} !== dly[3]) begin
      miscompares++;
      $display("FAIL ctl: got de/hs/vs=%b required %b at %0t",
               {de_out, hsync_out, vsync_out}, dly[3], $time);
    end
    if (de_out !== 1'b1) begin
      vectors++;
      if ({r_out, g_out, b_out} !== 24'd0) begin
        miscompares++;
        $display("FAIL blank_rgb: got (%0d,%0d,%0d) required (0,0,0) at %0t",
                 r_out, g_out, b_out, $time);
      end
    end else begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL extra_pixel: got (%0d,%0d,%0d) required no pixel at %0t",
                 r_out, g_out, b_out, $time);
      end else begin
        e = exp_q.pop_front();
        if ({r_out, g_out, b_out} !== e) begin
          miscompares++;
          $display("FAIL pixel: got (%0d,%0d,%0d) required (%0d,%0d,%0d) at %0t",
                   r_out, g_out, b_out, e.r, e.g, e.b, $time);
        end else begin
          $display("pixel ok (%0d,%0d,%0d) at %0t", r_out, g_out, b_out, $time);
        end
      end
    end
  end

  task automatic drive(input logic [7:0] y, input logic [7:0] c,
                       input logic de, input logic hs, input logic vs);
    @(negedge clk);
    hdmi_d     = (Y_IN_HIGH != 0) ? {y, c} : {c, y};
    hdmi_de    = de;
    hdmi_hsync = hs;
    hdmi_vsync = vs;
  endtask

  task automatic pix(input logic [7:0] y, input logic [7:0] c,
                     input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    drive(y, c, 1'b1, 1'b0, 1'b0);
    exp_q.push_back({r, g, b});
  endtask

  task automatic idle(input int n);
    repeat (n) drive(8'd16, 8'd128, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    hdmi_d = 16'h1080; hdmi_de = 1'b0; hdmi_hsync = 1'b0; hdmi_vsync = 1'b0;
    idle(4);
    rst = 1'b0;
    idle(2);

    // White pair
    pix(8'd235, 8'd128, 8'd255, 8'd255, 8'd255);
    pix(8'd235, 8'd128, 8'd255, 8'd255, 8'd255);
    idle(3);

    // Black pair followed by sync pulses in blanking
    pix(8'd16, 8'd128, 8'd0, 8'd0, 8'd0);
    pix(8'd16, 8'd128, 8'd0, 8'd0, 8'd0);
    drive(8'd16, 8'd128, 1'b0, 1'b1, 1'b0);
    drive(8'd16, 8'd128, 1'b0, 1'b1, 1'b0);
    drive(8'd16, 8'd128, 1'b0, 1'b0, 1'b1);
    idle(5);

    // Red pair then overflow pair in one line
    pix(8'd81, 8'd90, 8'd255, 8'd0, B_RED);
    pix(8'd81, 8'd240, 8'd255, 8'd0, B_RED);
    pix(8'd255, 8'd128, R_OV, 8'd175, B_OV);
    pix(8'd255, 8'd255, R_OV, 8'd175, B_OV);
    idle(3);

    // Mid-level pair, different Y per pixel, negative blue on the second
    pix(8'd126, 8'd100, 8'd163, 8'd121, 8'd72);
    pix(8'd60,  8'd150, 8'd86,  8'd44,  B_MIX);
    idle(2);

    // Odd-length line: last pixel is phase 0 with Cb=200, Cr forced neutral
    pix(8'd235, 8'd128, 8'd255, 8'd255, 8'd255);
    pix(8'd235, 8'd128, 8'd255, 8'd255, 8'd255);
    pix(8'd235, 8'd200, 8'd255, 8'd227, B_ODD);
    idle(2);

    // Next line starts at phase 0
    pix(8'd81, 8'd90, 8'd255, 8'd0, B_RED);
    pix(8'd81, 8'd240, 8'd255, 8'd0, B_RED);
    idle(2);

    // One-cycle DE glitch
    pix(8'd235, 8'd200, 8'd255, 8'd227, B_ODD);
    idle(5);

    // Reset mid-line: in-flight pixels are discarded
    drive(8'd235, 8'd128, 1'b1, 1'b0, 1'b0);
    drive(8'd235, 8'd128, 1'b1, 1'b0, 1'b0);
    drive(8'd235, 8'd128, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({r_out, g_out, b_out, hsync_out, vsync_out, de_out} !== 27'd0) begin
      miscompares++;
      $display("FAIL reset_clear: got (%0d,%0d,%0d) hs=%b vs=%b de=%b required all 0",
               r_out, g_out, b_out, hsync_out, vsync_out, de_out);
    end
    rst = 1'b0;
    hdmi_de = 1'b0;
    idle(3);
    pix(8'd81, 8'd90, 8'd255, 8'd0, B_RED);
    pix(8'd81, 8'd240, 8'd255, 8'd0, B_RED);
    idle(8);

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pixels still expected, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
